// File: rtl/uart_baud_pkg.sv
// uart_baud_pkg: shared types and constants for the UART baud-tick controller.
// Optional feature macro: UART_BAUD_FRAC_EN (fractional divisor).
package uart_baud_pkg;

    localparam int DIV_W   = 16;
    localparam int OS_RATE = 16;
    localparam int PH_W    = 4;

    localparam logic [DIV_W-1:0] DIV_RESET = 16'd977;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PEND
    } state_e;

    // A zero divisor would never reach terminal count; treat it as 1.
    function automatic logic [31:0] min_div(input logic [31:0] d);
        return (d == 32'd0) ? 32'd1 : d;
    endfunction

endpackage

// File: rtl/uart_baud_phase_ctr.sv
// uart_baud_phase_ctr: 4-bit oversample phase counter with clear.
// wrap flags the increment that rolls 15 -> 0 (the bit boundary).
module uart_baud_phase_ctr
    import uart_baud_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            inc,
    output logic [PH_W-1:0] phase,
    output logic            wrap
);

    logic [PH_W-1:0] phase_q;
    logic [PH_W-1:0] phase_d;

    always_comb begin
        phase_d = phase_q;
        if (clr) begin
            phase_d = '0;
        end else if (inc) begin
            phase_d = phase_q + PH_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;
    assign wrap  = inc && !clr && (phase_q == {PH_W{1'b1}});

endmodule

// File: rtl/uart_baud_ctrl.sv
// uart_baud_ctrl: programmable 16x oversample / 1x bit tick generator.
// Optional feature macro: UART_BAUD_FRAC_EN adds a 4-bit fractional divisor.
module uart_baud_ctrl
    import uart_baud_pkg::*;
#(
    parameter int               DIV_W     = uart_baud_pkg::DIV_W,
    parameter logic [DIV_W-1:0] DIV_RESET = DIV_W'(977),
    parameter int               OS_RATE   = uart_baud_pkg::OS_RATE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             rx_resync,
    input  logic             cfg_valid,
    input  logic [DIV_W-1:0] cfg_div,
`ifdef UART_BAUD_FRAC_EN
    input  logic [3:0]       cfg_frac,
`endif
    output logic             cfg_ready,
    output logic             os_tick,
    output logic             tx_tick,
    output logic [3:0]       os_phase,
    output logic             cfg_pending
);

    state_e           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] div_pend_q, div_pend_d;
    logic [DIV_W-1:0] acc_q, acc_d;
    logic             os_q, os_d;
    logic             tx_q, tx_d;

    logic [DIV_W-1:0] cfg_div_s;
    logic             xfer;
    logic             term;
    logic             ph_clr;
    logic             ph_inc;
    logic             ph_wrap;
    logic [3:0]       phase;

`ifdef UART_BAUD_FRAC_EN
    logic [3:0] frac_q, frac_d;
    logic [3:0] frac_pend_q, frac_pend_d;
    logic       ext;

    // Early phases of each bit get one extra clock.
    assign ext  = (phase < frac_q);
    assign term = ext ? (acc_q == div_q)
                      : (acc_q == div_q - DIV_W'(1));
`else
    assign term = (acc_q == div_q - DIV_W'(1));
`endif

    assign cfg_div_s = DIV_W'(min_div(32'(cfg_div)));
    assign cfg_ready = (state_q != PEND);
    assign xfer      = cfg_valid && cfg_ready;
    assign ph_clr    = !en || rx_resync;
    assign ph_inc    = en && !rx_resync && term;

    uart_baud_phase_ctr u_phase (
        .clk   (clk),
        .rst   (rst),
        .clr   (ph_clr),
        .inc   (ph_inc),
        .phase (phase),
        .wrap  (ph_wrap)
    );

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        div_pend_d = div_pend_q;
        acc_d      = acc_q;
        os_d       = 1'b0;
        tx_d       = 1'b0;
`ifdef UART_BAUD_FRAC_EN
        frac_d      = frac_q;
        frac_pend_d = frac_pend_q;
`endif

        if (!en || rx_resync) begin
            acc_d = '0;
        end else if (term) begin
            acc_d = '0;
            os_d  = 1'b1;
            tx_d  = ph_wrap;
        end else begin
            acc_d = acc_q + DIV_W'(1);
        end

        unique case (state_q)
            IDLE: begin
                if (xfer) begin
                    div_d = cfg_div_s;
`ifdef UART_BAUD_FRAC_EN
                    frac_d = cfg_frac;
`endif
                end
                if (en) state_d = RUN;
            end
            RUN: begin
                if (!en) begin
                    state_d = IDLE;
                    if (xfer) begin
                        div_d = cfg_div_s;
`ifdef UART_BAUD_FRAC_EN
                        frac_d = cfg_frac;
`endif
                    end
                end else if (xfer) begin
                    div_pend_d = cfg_div_s;
`ifdef UART_BAUD_FRAC_EN
                    frac_pend_d = cfg_frac;
`endif
                    state_d = PEND;
                end
            end
            PEND: begin
                // Apply on a bit boundary, a realignment, or when stopped.
                if (!en || rx_resync || ph_wrap) begin
                    div_d = div_pend_q;
`ifdef UART_BAUD_FRAC_EN
                    frac_d = frac_pend_q;
`endif
                    state_d = en ? RUN : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            div_q      <= DIV_RESET;
            div_pend_q <= '0;
            acc_q      <= '0;
            os_q       <= 1'b0;
            tx_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            div_pend_q <= div_pend_d;
            acc_q      <= acc_d;
            os_q       <= os_d;
            tx_q       <= tx_d;
        end
    end

`ifdef UART_BAUD_FRAC_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frac_q      <= '0;
            frac_pend_q <= '0;
        end else begin
            frac_q      <= frac_d;
            frac_pend_q <= frac_pend_d;
        end
    end
`endif

    assign os_tick     = os_q;
    assign tx_tick     = tx_q;
    assign os_phase    = phase;
    assign cfg_pending = (state_q == PEND);

endmodule

// File: tb/tb_uart_baud_ctrl.sv
// tb_uart_baud_ctrl: directed self-checking bench for uart_baud_ctrl.
// Expected values are hand-derived from the tick/phase arithmetic.
module tb_uart_baud_ctrl;

    logic        clk;
    logic        rst;
    logic        en;
    logic        rx_resync;
    logic        cfg_valid;
    logic [15:0] cfg_div;
`ifdef UART_BAUD_FRAC_EN
    logic [3:0]  cfg_frac;
`endif
    logic        cfg_ready;
    logic        os_tick;
    logic        tx_tick;
    logic [3:0]  os_phase;
    logic        cfg_pending;

    int n_checks;
    int n_fail;

    uart_baud_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .rx_resync   (rx_resync),
        .cfg_valid   (cfg_valid),
        .cfg_div     (cfg_div),
`ifdef UART_BAUD_FRAC_EN
        .cfg_frac    (cfg_frac),
`endif
        .cfg_ready   (cfg_ready),
        .os_tick     (os_tick),
        .tx_tick     (tx_tick),
        .os_phase    (os_phase),
        .cfg_pending (cfg_pending)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, expv, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        en        = 1'b0;
        rx_resync = 1'b0;
        cfg_valid = 1'b0;
        cfg_div   = '0;
`ifdef UART_BAUD_FRAC_EN
        cfg_frac  = '0;
`endif
        step();
        step();
        check("rst_os", 32'(os_tick), 0);
        check("rst_tx", 32'(tx_tick), 0);
        check("rst_phase", 32'(os_phase), 0);
        check("rst_ready", 32'(cfg_ready), 1);
        check("rst_pend", 32'(cfg_pending), 0);
        rst = 1'b0;
        step();
        check("idle_os", 32'(os_tick), 0);

        // Default divisor: first os_tick on edge 977.
        en = 1'b1;
        for (int k = 1; k <= 977; k++) begin
            step();
            check("def_os", 32'(os_tick), 32'(k == 977));
        end
        check("def_phase", 32'(os_phase), 1);
        en = 1'b0;
        step();
        check("dis_os", 32'(os_tick), 0);
        check("dis_phase", 32'(os_phase), 0);

        // Load divisor 4 in IDLE, then run up to phase 5.
        cfg_valid = 1'b1;
        cfg_div   = 16'd4;
        step();
        cfg_valid = 1'b0;
        en = 1'b1;
        for (int n = 1; n <= 84; n++) begin
            step();
            check("d4_os", 32'(os_tick), 32'(n % 4 == 0));
            check("d4_tx", 32'(tx_tick), 32'(n % 64 == 0));
            check("d4_phase", 32'(os_phase), 32'((n / 4) % 16));
        end

        // Running update to 8, deferred to the tx_tick at edge 128.
        cfg_valid = 1'b1;
        cfg_div   = 16'd8;
        check("upd_ready_pre", 32'(cfg_ready), 1);
        step();
        cfg_valid = 1'b0;
        cfg_div   = 16'd3;
        check("upd_ready", 32'(cfg_ready), 0);
        check("upd_pend", 32'(cfg_pending), 1);
        check("upd_os85", 32'(os_tick), 0);
        for (int n = 86; n <= 144; n++) begin
            step();
            check("upd_os", 32'(os_tick),
                  32'(n <= 128 ? (n % 4 == 0) : (n % 8 == 0)));
            check("upd_tx", 32'(tx_tick), 32'(n == 128));
            check("upd_pend", 32'(cfg_pending), 32'(n < 128));
            check("upd_ready", 32'(cfg_ready), 32'(n >= 128));
            check("upd_phase", 32'(os_phase),
                  32'(n <= 128 ? (n / 4) % 16 : (n - 128) / 8));
        end

        // Resync on the terminal-count edge suppresses the tick.
        for (int n = 145; n <= 151; n++) begin
            step();
            check("pre_rs_os", 32'(os_tick), 0);
        end
        rx_resync = 1'b1;
        step();
        rx_resync = 1'b0;
        check("rs_os", 32'(os_tick), 0);
        check("rs_tx", 32'(tx_tick), 0);
        check("rs_phase", 32'(os_phase), 0);
        for (int k = 1; k <= 8; k++) begin
            step();
            check("post_rs_os", 32'(os_tick), 32'(k == 8));
        end
        check("post_rs_phase", 32'(os_phase), 1);

        // Divisor 0 sanitised to 1: os_tick every cycle.
        en = 1'b0;
        step();
        check("stop_os", 32'(os_tick), 0);
        check("stop_phase", 32'(os_phase), 0);
        cfg_valid = 1'b1;
        cfg_div   = 16'd0;
        step();
        cfg_valid = 1'b0;
        en = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
            check("d0_os", 32'(os_tick), 1);
            check("d0_tx", 32'(tx_tick), 32'(k % 16 == 0));
            check("d0_phase", 32'(os_phase), 32'(k % 16));
        end
        en = 1'b0;
        step();
        check("d0_dis_os", 32'(os_tick), 0);
        en = 1'b1;
        step();
        step();
        check("d0_rerun_os", 32'(os_tick), 1);

        // Asynchronous reset between edges.
        #3;
        rst = 1'b1;
        #1;
        check("arst_os", 32'(os_tick), 0);
        check("arst_tx", 32'(tx_tick), 0);
        check("arst_phase", 32'(os_phase), 0);
        check("arst_ready", 32'(cfg_ready), 1);
        check("arst_pend", 32'(cfg_pending), 0);
        en = 1'b0;
        step();
        rst = 1'b0;

        // Transfer coincident with en falling loads div directly.
        en = 1'b1;
        step();
        step();
        step();
        en        = 1'b0;
        cfg_valid = 1'b1;
        cfg_div   = 16'd2;
        step();
        cfg_valid = 1'b0;
        check("drop_pend", 32'(cfg_pending), 0);
        check("drop_ready", 32'(cfg_ready), 1);
        check("drop_os", 32'(os_tick), 0);
        en = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            check("drop_d2_os", 32'(os_tick), 32'(k % 2 == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_baud_ctrl.md
Name: uart_baud_ctrl

Overview:
Programmable baud-tick controller for the UART. It owns the divisor register and produces the 16x oversampling tick (os_tick) and the 1x bit tick (tx_tick). It accepts divisor updates through a valid/ready handshake. Updates are deferred to a bit boundary so a running frame never sees a short or long bit. It sits between the register/config interface and the UART TX/RX engines, and replaces free-running fixed-divisor tick generation.

Parameters:
- DIV_W, 16, width of the divisor and of the cycle accumulator.
- DIV_RESET, 977, divisor loaded at reset (150 MHz / (9600*16), rounded).
- OS_RATE, 16, oversampling ratio; fixed at 16 (phase counter is 4 bits).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- en  in  1  tick generation enable
- rx_resync  in  1  one-cycle pulse from RX on start-bit detect; realigns phase
- cfg_valid  in  1  new divisor offered
- cfg_div  in  DIV_W  new divisor value
- cfg_ready  out  1  divisor can be accepted this cycle
- os_tick  out  1  one-cycle pulse every div_q clocks
- tx_tick  out  1  one-cycle pulse every 16 os_ticks, coincident with the 16th
- os_phase  out  4  current oversample phase, 0..15
- cfg_pending  out  1  accepted divisor is waiting for a bit boundary

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; div_q=DIV_RESET; acc=0; phase=0; div_pend=0.
  - os_tick, tx_tick, cfg_pending and os_phase are 0; cfg_ready=1.
- Divisor sanitising: cfg_div==0 is stored as 1. div_q=1 gives os_tick high every cycle.
- Accumulator, on each edge with en=1:
  - If acc==div_q-1: acc<=0 and os_tick<=1.
  - Otherwise acc<=acc+1 and os_tick<=0.
  - With div_q=4, os_tick is high after edges 4, 8, 12, and so on, counted from the first edge with en=1.
- Phase counter: on the edge that raises os_tick, phase<=phase+1 (mod 16).
- tx_tick: registered. tx_tick<=1 on the same edge where os_tick<=1 and phase==15; the phase wraps to 0 on that edge.
- Outputs os_tick and tx_tick are registered. os_phase=phase.
- cfg_ready = (state!=PEND), combinational. A transfer occurs when cfg_valid && cfg_ready.
- State machine:
  - IDLE (en=0):
    - Transfer: div_q<=cfg_div on the next edge.
    - en=1: go to RUN.
  - RUN:
    - Transfer: div_pend<=cfg_div and go to PEND.
    - en=0: go to IDLE.
  - PEND:
    - On the edge that asserts tx_tick: div_q<=div_pend, acc<=0, go to RUN.
    - rx_resync=1: apply the pending divisor immediately, go to RUN.
    - en=0: apply the pending divisor immediately, go to IDLE.
- cfg_pending = (state==PEND).
- en deassert: on the next edge acc, phase, os_tick and tx_tick are cleared. No tick is emitted on that edge, even if acc==div_q-1.
- rx_resync (en=1):
  - acc<=0 and phase<=0; no os_tick or tx_tick that edge.
  - Wins over a coincident terminal count.
  - A simultaneous cfg transfer is still accepted; in RUN it goes to PEND.
- Simultaneous transfer and en falling: in RUN the new divisor loads directly into div_q and the state goes to IDLE.
- A cfg_div change without cfg_valid has no effect.

Optional Feature:
- UART_BAUD_FRAC_EN defined:
  - Adds input cfg_frac[3:0], captured alongside cfg_div.
  - Adds frac_q/frac_pend, which follow the same deferral rules as the divisor.
  - For os periods with phase < frac_q the period is div_q+1 clocks. Mean os period = div_q + frac_q/16.
  - Reset value of frac_q is 0.
- Not defined: no cfg_frac port; all os periods are exactly div_q.

Decomposition:
- Package uart_baud_pkg:
  - DIV_W default and OS_RATE=16.
  - State enum {IDLE, RUN, PEND}.
  - DIV_RESET constant, and a min-divisor function that clamps 0 to 1.
- Sub-module uart_baud_phase_ctr: 4-bit phase counter with clear. Outputs phase and the wrap indication used for tx_tick.

Test Plan:
- Reset, en=1, default divisor: os_tick period 977 clocks; tx_tick every 15632 clocks; os_phase sequences 0..15.
- IDLE config: cfg_div=4, then en=1: os_tick after edges 4, 8, 12; tx_tick coincident with the 16th os_tick (edge 64).
- Running update with div=4 at phase 5:
  - Send cfg_div=8: cfg_ready drops and cfg_pending=1.
  - Periods stay 4 until the tx_tick edge, then become 8; cfg_ready returns to 1.
- rx_resync at acc==div_q-1: no os_tick that cycle; os_phase=0; the next os_tick arrives exactly div_q clocks later.
- cfg_div=0: os_tick continuously high and tx_tick every 16 clocks. Asserting rst mid-count clears all outputs immediately, without waiting for a clock edge.
- UART_BAUD_FRAC_EN build, div=4 and frac=4: phases 0..3 last 5 clocks and phases 4..15 last 4 clocks, so the tx_tick period is 68 clocks.
